// File: rtl/count_mon_pkg.sv
// Shared types for the count direction monitor: FSM states, step classes, run counter width.
package count_mon_pkg;

  localparam int unsigned RUN_W = 3;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ACQ   = 2'd1,
    S_UP    = 2'd2,
    S_DOWN  = 2'd3
  } mon_state_t;

  typedef enum logic [1:0] {
    C_HOLD = 2'd0,
    C_UP   = 2'd1,
    C_DOWN = 2'd2,
    C_JUMP = 2'd3
  } step_class_t;

endpackage

// File: rtl/step_classifier.sv
// Classifies a count step as hold, up, down or jump from the modular difference
// between the new sample and the previous one; wrap-around counts as adjacent.
module step_classifier
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [0:WIDTH-1] q_in,
  input  logic [WIDTH-1:0] prev,
  output step_class_t      step_class
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_delta;

  // q_in[0] is the MSB, so a plain assignment lands it in w_q[WIDTH-1]
  assign w_q     = q_in;
  assign w_delta = w_q - prev;

  always_comb begin
    step_class = C_JUMP;
    if (w_delta == '0)
      step_class = C_HOLD;
    else if (w_delta == WIDTH'(1))
      step_class = C_UP;
    else if (w_delta == {WIDTH{1'b1}})
      step_class = C_DOWN;
  end

endmodule

// File: rtl/count_direction_monitor.sv
// Watches a sampled count stream, locks onto its direction after LOCK_STEPS
// consecutive same-direction steps, flags jumps/reversals and tracks a wrapping position.
module count_direction_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned LOCK_STEPS = 2,
  parameter int unsigned POS_W      = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [0:WIDTH-1] q_in,
  input  logic             sample_en,
  output logic             ud_out,
  output logic             locked,
  output logic             hold,
  output logic             err,
  output logic             rev,
  output logic [POS_W-1:0] pos
);

  localparam logic [RUN_W-1:0] LOCK_R = RUN_W'(LOCK_STEPS);
  localparam logic [RUN_W-1:0] ONE_R  = RUN_W'(1);

  mon_state_t       r_state;
  logic [WIDTH-1:0] r_prev;
  logic [RUN_W-1:0] r_run;
  logic             r_ud;
  logic             r_locked;
  logic             r_hold;
  logic             r_err;
  logic             r_rev;
  logic [POS_W-1:0] r_pos;

  logic [WIDTH-1:0] w_q;
  step_class_t      w_class;
  logic [RUN_W-1:0] w_run_inc;
  logic [RUN_W-1:0] w_run_up;
  logic [RUN_W-1:0] w_run_dn;

  assign w_q = q_in;

  step_classifier #(.WIDTH(WIDTH)) u_classifier (
    .q_in       (q_in),
    .prev       (r_prev),
    .step_class (w_class)
  );

  // A step continues the run only if it agrees with the current direction
  assign w_run_inc = (r_run >= LOCK_R) ? LOCK_R : r_run + ONE_R;
  assign w_run_up  = r_ud  ? w_run_inc : ONE_R;
  assign w_run_dn  = !r_ud ? w_run_inc : ONE_R;

  always_ff @(posedge clk) begin
    if (!clear) begin
      r_state  <= S_EMPTY;
      r_prev   <= '0;
      r_run    <= '0;
      r_ud     <= 1'b0;
      r_locked <= 1'b0;
      r_hold   <= 1'b0;
      r_err    <= 1'b0;
      r_rev    <= 1'b0;
      r_pos    <= '0;
    end else if (sample_en) begin
      r_prev <= w_q;
      r_err  <= 1'b0;
      r_rev  <= 1'b0;
      if (r_state == S_EMPTY) begin
        r_state <= S_ACQ;
      end else begin
        r_hold <= (w_class == C_HOLD);
        unique case (w_class)
          C_HOLD: ;
          C_UP: begin
            r_pos <= r_pos + POS_W'(1);
            case (r_state)
              S_ACQ: begin
                r_ud  <= 1'b1;
                r_run <= w_run_up;
                if (w_run_up >= LOCK_R) begin
                  r_state  <= S_UP;
                  r_locked <= 1'b1;
                end
              end
              S_DOWN: begin
                r_rev <= 1'b1;
                r_ud  <= 1'b1;
                r_run <= ONE_R;
                if (LOCK_STEPS == 1) begin
                  r_state <= S_UP;
                end else begin
                  r_state  <= S_ACQ;
                  r_locked <= 1'b0;
                end
              end
              default: ;
            endcase
          end
          C_DOWN: begin
            r_pos <= r_pos - POS_W'(1);
            case (r_state)
              S_ACQ: begin
                r_ud  <= 1'b0;
                r_run <= w_run_dn;
                if (w_run_dn >= LOCK_R) begin
                  r_state  <= S_DOWN;
                  r_locked <= 1'b1;
                end
              end
              S_UP: begin
                r_rev <= 1'b1;
                r_ud  <= 1'b0;
                r_run <= ONE_R;
                if (LOCK_STEPS == 1) begin
                  r_state <= S_DOWN;
                end else begin
                  r_state  <= S_ACQ;
                  r_locked <= 1'b0;
                end
              end
              default: ;
            endcase
          end
          C_JUMP: begin
            r_err    <= 1'b1;
            r_locked <= 1'b0;
            r_run    <= '0;
            r_state  <= S_ACQ;
          end
        endcase
      end
    end else begin
      r_err <= 1'b0;
      r_rev <= 1'b0;
    end
  end

  assign ud_out = r_ud;
  assign locked = r_locked;
  assign hold   = r_hold;
  assign err    = r_err;
  assign rev    = r_rev;
  assign pos    = r_pos;

endmodule

// File: doc/count_direction_monitor.md
Name: count_direction_monitor

Overview:
Reader-side companion to the synchronous up/down counters. It samples a WIDTH-bit count stream, classifies each sampled step as up, down, hold or illegal jump, and locks onto a direction after LOCK_STEPS consecutive same-direction steps. It also accumulates a wrapping position, so a downstream block can verify or track any counter in the design without access to its ud control.

Parameters:
WIDTH, 3, bit width of monitored count
LOCK_STEPS, 2, consecutive same-direction steps required to lock (1..7)
POS_W, 8, width of wrapping position accumulator

Ports:
clk  input  1  rising-edge clock
clear  input  1  synchronous active-low reset
q_in  input  [0:WIDTH-1]  monitored count; q_in[0] is MSB
sample_en  input  1  q_in valid this cycle
ud_out  output  1  detected direction, 1=up, 0=down (same sense as counter ud)
locked  output  1  direction locked
hold  output  1  last sample equalled previous sample
err  output  1  one-cycle pulse on illegal jump
rev  output  1  one-cycle pulse on direction reversal while locked
pos  output  [POS_W-1:0]  signed-wrap step accumulator

Behaviour:
- One clock (clk). Reset is synchronous and active-low (clear low at a rising edge). Reset has priority over sample_en.
- Reset values: state=S_EMPTY, prev=0, run=0, ud_out=0, locked=0, hold=0, err=0, rev=0, pos=0.
- All outputs are registered and reflect a sample on the edge following the one that captured it (1-cycle latency).
- sample_en low: all state held; err and rev return to 0; hold is held.
- Step class on sample_en with a valid prev: delta = (q_in - prev) mod 2^WIDTH.
  - delta=0: HOLD.
  - delta=1: UP.
  - delta=2^WIDTH-1: DOWN.
  - otherwise: JUMP.
- Wrap-around is legal: 7->0 is UP and 0->7 is DOWN (WIDTH=3).
- prev <= q_in on every accepted sample, including JUMP.
- FSM states: S_EMPTY, S_ACQ, S_UP, S_DOWN.
  - S_EMPTY: first sample captures prev only, with no classification; go to S_ACQ.
  - S_ACQ, UP: if ud_out=1 then run++, else run=1 and ud_out<=1. When run reaches LOCK_STEPS, go to S_UP and set locked=1.
  - S_ACQ, DOWN: mirror of UP with ud_out<=0, going to S_DOWN.
  - S_ACQ, HOLD: no change to run.
  - S_ACQ, JUMP: err pulse, run=0.
  - S_UP, UP or HOLD: stay.
  - S_UP, DOWN: rev pulse, locked=0, ud_out=0, run=1, go to S_ACQ. If LOCK_STEPS=1, go directly to S_DOWN with locked kept at 1.
  - S_DOWN: mirror of S_UP.
  - Any state except S_EMPTY, JUMP: err pulse, locked=0, run=0, go to S_ACQ. ud_out is unchanged.
- hold <= 1 on HOLD and 0 on any other class.
- pos: +1 on UP, -1 on DOWN, in every state. Unchanged on HOLD and JUMP. Wraps mod 2^POS_W with no saturation.
- run saturates at LOCK_STEPS.
- err and rev are never asserted in the same cycle.

Decomposition:
- Shared package count_mon_pkg holds:
  - state enum (S_EMPTY, S_ACQ, S_UP, S_DOWN)
  - step class enum (C_HOLD, C_UP, C_DOWN, C_JUMP)
  - run counter width constant (3 bits)
- One combinational sub-module, step_classifier: inputs q_in and prev, output is the step class. It is reusable by other checkers.
- The FSM, run counter and pos accumulator stay in count_direction_monitor.

Test Plan:
- Reset, then samples 0,1,2,3 every cycle -> locked=1 one cycle after the 2 sample, ud_out=1, pos=3, err never asserted.
- Samples 5,4,3 -> locked down, ud_out=0. Then sample 2 followed by 3 -> rev pulse on the 3, locked=0, pos net +(-3)+1 relative to start.
- Samples 6,7,0,1 -> wrap classified UP, locked=1, pos=3. Then 1,0,7 -> DOWN across the wrap, pos=1.
- Samples 2,3,4, then 7 -> err pulse for one cycle, locked=0, pos unchanged by the jump. Next sample 0 -> UP, run=1.
- Samples 3,3,3 while locked up -> hold=1, locked stays 1, pos unchanged. sample_en low for 5 cycles -> all outputs stable, err=0.
- Drive clear=0 mid-sequence with sample_en=1 -> next edge gives all reset values. The following first sample only captures prev (no err even when non-adjacent).
